// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the multi-channel clock divider.
//   NUM_CH_DEF        default channel count
//   RATIO_W_DEF       default width of a channel ratio field
//   EDGE_CNT_W_DEF    default width of the optional per-channel edge counter
//   RATIO_BYPASS_MAX  largest ratio value that selects bypass (0 and 1)
//   half_ceil(r)      ceil(r/2), length of the divided high phase
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned NUM_CH_DEF       = 4;
    localparam int unsigned RATIO_W_DEF      = 8;
    localparam int unsigned EDGE_CNT_W_DEF   = 16;
    localparam int unsigned RATIO_BYPASS_MAX = 1;

    // Written as floor + lsb so r = 2^32-1 cannot overflow.
    function automatic int unsigned half_ceil(input int unsigned r);
        return (r >> 1) + (r & 32'd1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One divider channel: period counter, shadow (active) ratio, registered
// divided clock, tick decode and bypass mux.
// Optional feature (macro CLK_DIV_EDGE_CNT_EN): per-channel edge counter.
//
// Ports:
//   i_clk       reference clock, all state on posedge
//   i_rst       synchronous active-high reset
//   i_clk_en    divide enable, 0 = bypass
//   i_ratio     requested ratio; 0 and 1 also mean bypass
//   i_sync      restart at phase 0 on the next edge
//   o_div_clk   divided clock (or i_clk in bypass)
//   o_tick      one-cycle pulse in the first cycle of each high phase
//   i_cnt_clr   (CLK_DIV_EDGE_CNT_EN) clear the edge counter
//   o_edge_cnt  (CLK_DIV_EDGE_CNT_EN) divided rising edges seen
// ---------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_W    = RATIO_W_DEF
`ifdef CLK_DIV_EDGE_CNT_EN
    ,
    parameter int unsigned EDGE_CNT_W = EDGE_CNT_W_DEF
`endif
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_ratio,
    input  logic               i_sync,
`ifdef CLK_DIV_EDGE_CNT_EN
    input  logic               i_cnt_clr,
    output logic [EDGE_CNT_W-1:0] o_edge_cnt,
`endif
    output logic               o_div_clk,
    output logic               o_tick
);

    logic [RATIO_W-1:0] r_act;
    logic [RATIO_W-1:0] r_cnt;
    logic               r_term;
    logic               r_out;

    logic [RATIO_W-1:0] w_act_nxt;
    logic [RATIO_W-1:0] w_cnt_nxt;
    logic               w_term_nxt;
    logic               w_out_nxt;
    logic               w_bypass;
    logic               w_wrap;
    logic [RATIO_W-1:0] w_half;

    assign w_bypass = !i_clk_en || (r_act <= RATIO_W'(RATIO_BYPASS_MAX));
    // ">=" rather than "==" keeps cnt inside the period even if it were ever
    // out of range; in divide mode r_act >= 2 so the subtraction cannot wrap.
    assign w_wrap   = r_term || (r_cnt >= (r_act - RATIO_W'(1)));
    assign w_half   = RATIO_W'(half_ceil(32'(r_act)));

    always_comb begin
        w_act_nxt  = r_act;
        w_cnt_nxt  = r_cnt;
        w_term_nxt = r_term;
        w_out_nxt  = r_out;
        if (i_sync || w_bypass) begin
            // Park at "about to start phase 0"; ratio tracks the input.
            w_act_nxt  = i_ratio;
            w_cnt_nxt  = '0;
            w_term_nxt = 1'b1;
            w_out_nxt  = 1'b0;
        end else begin
            w_term_nxt = 1'b0;
            if (w_wrap) begin
                // New ratio only takes effect at a period boundary.
                w_cnt_nxt = '0;
                w_act_nxt = i_ratio;
            end else begin
                w_cnt_nxt = r_cnt + RATIO_W'(1);
            end
            w_out_nxt = (w_cnt_nxt < w_half);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_act  <= i_ratio;
            r_cnt  <= '0;
            r_term <= 1'b1;
            r_out  <= 1'b0;
        end else begin
            r_act  <= w_act_nxt;
            r_cnt  <= w_cnt_nxt;
            r_term <= w_term_nxt;
            r_out  <= w_out_nxt;
        end
    end

    assign o_tick    = (r_cnt == '0) && r_out && !w_bypass;
    assign o_div_clk = w_bypass ? i_clk : r_out;

`ifdef CLK_DIV_EDGE_CNT_EN
    logic [EDGE_CNT_W-1:0] r_edge_cnt;

    // In bypass every reference cycle is a divided rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            r_edge_cnt <= '0;
        end else if (o_tick || w_bypass) begin
            r_edge_cnt <= r_edge_cnt + EDGE_CNT_W'(1);
        end
    end

    assign o_edge_cnt = r_edge_cnt;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// NUM_CH independent clock dividers fed from one reference clock, with
// glitch-free ratio update, per-channel tick and global phase re-alignment.
// Optional feature (macro CLK_DIV_EDGE_CNT_EN): per-channel edge counters.
//
// Ports:
//   CLK          reference clock, all state on posedge
//   RST          synchronous active-high reset
//   i_clk_en     per-channel divide enable, 0 = bypass
//   i_div_ratio  channel k ratio in bits [k*RATIO_W +: RATIO_W]
//   i_sync       single-cycle pulse, restarts all channels at phase 0
//   i_cnt_clr    (CLK_DIV_EDGE_CNT_EN) clear all edge counters
//   o_edge_cnt   (CLK_DIV_EDGE_CNT_EN) channel k in [k*EDGE_CNT_W +: EDGE_CNT_W]
//   o_div_clk    divided clock per channel
//   o_tick       one-cycle pulse per divided rising edge
// ---------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned RATIO_W    = RATIO_W_DEF,
    parameter int unsigned EDGE_CNT_W = EDGE_CNT_W_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_CH-1:0]         i_clk_en,
    input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
    input  logic                      i_sync,
`ifdef CLK_DIV_EDGE_CNT_EN
    input  logic                      i_cnt_clr,
    output logic [NUM_CH*EDGE_CNT_W-1:0] o_edge_cnt,
`endif
    output logic [NUM_CH-1:0]         o_div_clk,
    output logic [NUM_CH-1:0]         o_tick
);

    // One shared sync line so every channel restarts on the same edge.
    logic w_sync;
    assign w_sync = i_sync;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_chan #(
            .RATIO_W    (RATIO_W)
`ifdef CLK_DIV_EDGE_CNT_EN
            ,
            .EDGE_CNT_W (EDGE_CNT_W)
`endif
        ) u_chan (
            .i_clk      (CLK),
            .i_rst      (RST),
            .i_clk_en   (i_clk_en[k]),
            .i_ratio    (i_div_ratio[k*RATIO_W +: RATIO_W]),
            .i_sync     (w_sync),
`ifdef CLK_DIV_EDGE_CNT_EN
            .i_cnt_clr  (i_cnt_clr),
            .o_edge_cnt (o_edge_cnt[k*EDGE_CNT_W +: EDGE_CNT_W]),
`endif
            .o_div_clk  (o_div_clk[k]),
            .o_tick     (o_tick[k])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
// Directed self-checking bench for clk_div_multi (4 channels, 8-bit ratios).
// Edge counts come from event monitors on o_div_clk; tick counts are taken
// at each CLK posedge (value of the cycle just ending). Outputs are sampled
// on the CLK negedge.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned RW  = 8;
    localparam int unsigned EW  = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NCH-1:0]    i_clk_en;
    logic [NCH*RW-1:0] i_div_ratio;
    logic              i_sync;
    logic [NCH-1:0]    w_div_clk;
    logic [NCH-1:0]    w_tick;
`ifdef CLK_DIV_EDGE_CNT_EN
    logic              i_cnt_clr;
    logic [NCH*EW-1:0] w_edge_cnt;
`endif

    clk_div_multi #(
        .NUM_CH     (NCH),
        .RATIO_W    (RW),
        .EDGE_CNT_W (EW)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_clk_en    (i_clk_en),
        .i_div_ratio (i_div_ratio),
        .i_sync      (i_sync),
`ifdef CLK_DIV_EDGE_CNT_EN
        .i_cnt_clr   (i_cnt_clr),
        .o_edge_cnt  (w_edge_cnt),
`endif
        .o_div_clk   (w_div_clk),
        .o_tick      (w_tick)
    );

    always #5 CLK = ~CLK;

    // Free-running monitors; windows are measured as differences.
    int unsigned edges0 = 0;
    int unsigned edges1 = 0;
    int unsigned edges2 = 0;
    int unsigned edges3 = 0;
    int unsigned ticks[NCH] = '{default: 0};

    always @(posedge w_div_clk[0]) edges0++;
    always @(posedge w_div_clk[1]) edges1++;
    always @(posedge w_div_clk[2]) edges2++;
    always @(posedge w_div_clk[3]) edges3++;

    always @(posedge CLK) begin
        for (int k = 0; k < NCH; k++) begin
            if (w_tick[k]) ticks[k] = ticks[k] + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int unsigned win_e[NCH];
    int unsigned win_t[NCH];

    task automatic check_eq(input string tag, input longint unsigned obs,
                            input longint unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ratio(input int k, input logic [RW-1:0] v);
        i_div_ratio[k*RW +: RW] = v;
    endtask

    // Called at a negedge; returns at the negedge after sync took effect.
    task automatic pulse_sync();
        i_sync = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        i_sync = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called at a negedge; counts over the next 'cycles' posedges.
    task automatic run_window(input int cycles);
        int unsigned e0[NCH];
        int unsigned t0[NCH];
        e0 = '{edges0, edges1, edges2, edges3};
        t0 = ticks;
        repeat (cycles) @(posedge CLK);
        @(negedge CLK);
        win_e[0] = edges0 - e0[0];
        win_e[1] = edges1 - e0[1];
        win_e[2] = edges2 - e0[2];
        win_e[3] = edges3 - e0[3];
        for (int k = 0; k < NCH; k++) win_t[k] = ticks[k] - t0[k];
    endtask

    logic [5:0]  pat6;
    logic [10:0] pat11;
    int unsigned coinc;
    int unsigned t24_0;
    int unsigned t24_1;

    initial begin
        RST         = 1'b1;
        i_sync      = 1'b0;
        i_clk_en    = 4'b0111;
        i_div_ratio = '0;
`ifdef CLK_DIV_EDGE_CNT_EN
        i_cnt_clr   = 1'b0;
`endif
        set_ratio(0, 8'd2);
        set_ratio(1, 8'd2);
        set_ratio(2, 8'd5);
        set_ratio(3, 8'd2);

        // Reset state.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_div_clk", w_div_clk[2:0], 3'b000);
        check_eq("rst_tick", w_tick, 4'b0000);

        // First posedge after release starts phase 0.
        RST = 1'b0;
        step();
        check_eq("first_rise", w_div_clk[2:0], 3'b111);
        check_eq("first_tick", w_tick, 4'b0111);

        // Ratio 2 on ch0 and bypass on ch3 over 300 cycles.
        run_window(300);
        check_eq("r2_edges", win_e[0], 150);
        check_eq("r2_ticks", win_t[0], 150);
        check_eq("r5_edges_a", win_e[2], 60);
        check_eq("byp_edges", win_e[3], 300);
        check_eq("byp_ticks", win_t[3], 0);

        // Ratios 3, 4, 5 after a sync.
        set_ratio(0, 8'd3);
        set_ratio(1, 8'd4);
        set_ratio(2, 8'd5);
        pulse_sync();
        check_eq("sync_low", w_div_clk[2:0], 3'b000);
        run_window(300);
        check_eq("r3_edges", win_e[0], 100);
        check_eq("r4_edges", win_e[1], 75);
        check_eq("r5_edges", win_e[2], 60);
        check_eq("r3_ticks", win_t[0], 100);
        check_eq("r4_ticks", win_t[1], 75);
        check_eq("r5_ticks", win_t[2], 60);
        check_eq("byp_edges_b", win_e[3], 300);

        // Ratio 3 duty: high 2, low 1.
        pulse_sync();
        pat6 = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            pat6 = {pat6[4:0], w_div_clk[0]};
        end
        check_eq("r3_duty", pat6, 6'b110110);

        // Mid-period ratio change 4 -> 6 written at cnt=1.
        set_ratio(0, 8'd4);
        pulse_sync();
        pat11 = '0;
        for (int i = 0; i < 11; i++) begin
            step();
            pat11 = {pat11[9:0], w_div_clk[0]};
            if (i == 1) set_ratio(0, 8'd6);
        end
        check_eq("ratio_update", pat11, 11'b11001110001);

        // Sync alignment of ratio 4 and ratio 6.
        set_ratio(0, 8'd4);
        set_ratio(1, 8'd6);
        pulse_sync();
        coinc = 0;
        t24_0 = 0;
        t24_1 = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 0) check_eq("sync_align", {w_div_clk[1:0], w_tick[1:0]}, 4'b1111);
            if (w_tick[1:0] == 2'b11) coinc++;
            if (w_tick[0]) t24_0++;
            if (w_tick[1]) t24_1++;
        end
        check_eq("sync_coinc", coinc, 2);
        check_eq("sync_t4", t24_0, 6);
        check_eq("sync_t6", t24_1, 4);

        // Boundaries: ratio 0 and 1 bypass, ratio 255 maximum.
        set_ratio(0, 8'd0);
        set_ratio(1, 8'd1);
        set_ratio(2, 8'd255);
        set_ratio(3, 8'd2);
        i_clk_en = 4'b1111;
        pulse_sync();
        run_window(510);
        check_eq("r0_edges", win_e[0], 510);
        check_eq("r1_edges", win_e[1], 510);
        check_eq("r0_ticks", win_t[0], 0);
        check_eq("r1_ticks", win_t[1], 0);
        check_eq("r255_edges", win_e[2], 2);
        check_eq("r255_ticks", win_t[2], 2);
        check_eq("r2b_edges", win_e[3], 255);

        // Reset in the middle of a ratio-5 period.
        set_ratio(0, 8'd5);
        set_ratio(1, 8'd5);
        set_ratio(2, 8'd5);
        pulse_sync();
        step();
        step();
        RST = 1'b1;
        step();
        check_eq("midrst_div", w_div_clk, 4'b0000);
        check_eq("midrst_tick", w_tick, 4'b0000);
`ifdef CLK_DIV_EDGE_CNT_EN
        check_eq("midrst_ecnt", w_edge_cnt, 0);
`endif
        RST = 1'b0;
        step();
        check_eq("rel_div", w_div_clk, 4'b1111);
        check_eq("rel_tick", w_tick, 4'b1111);
`ifdef CLK_DIV_EDGE_CNT_EN
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        check_eq("ecnt_r5", w_edge_cnt[0 +: EW], 2);
        check_eq("ecnt_r2", w_edge_cnt[3*EW +: EW], 5);
        // Clear coincides with a pending increment on ch0 and ch3.
        i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
        check_eq("ecnt_clr", w_edge_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel, parametrised clock divider; successor to the single-channel 5-bit divider.
- NUM_CH independent channels, each divides the reference clock by a runtime ratio of RATIO_W bits.
- Adds glitch-free ratio update at period boundaries, a per-channel tick pulse, and global phase re-alignment.
- Feeds peripheral/UART baud clocks from one reference clock.

Parameters:
- NUM_CH, 4: number of divider channels (1..16).
- RATIO_W, 8: width of each channel's ratio field.
- EDGE_CNT_W, 16: width of the optional per-channel edge counter.

Ports:
- CLK  in  1  reference clock; all state on posedge.
- RST  in  1  synchronous, active-high reset.
- i_clk_en  in  NUM_CH  per-channel divide enable; 0 = bypass.
- i_div_ratio  in  NUM_CH*RATIO_W  channel k ratio in bits [k*RATIO_W +: RATIO_W].
- i_sync  in  1  single-cycle pulse; restarts all channels at phase 0.
- o_div_clk  out  NUM_CH  divided clock per channel.
- o_tick  out  NUM_CH  one-cycle pulse marking each divided rising edge.

Behaviour:
- Per-channel state:
  - r_act: active ratio, RATIO_W bits.
  - cnt: counter, RATIO_W bits.
  - term: terminal flag.
  - out_q: registered divided clock.
- Reset (RST=1 at posedge):
  - cnt=0, term=1, out_q=0.
  - r_act loads i_div_ratio.
  - o_tick=0, o_div_clk=0 for dividing channels.
- Divide mode (i_clk_en=1 and r_act>=2):
  - Next cnt is 0 when term=1 or cnt==r_act-1; otherwise cnt+1.
  - term clears once counting.
  - out_q <= (next cnt < ceil(r_act/2)).
  - Duty cycle: high ceil(R/2) cycles, low floor(R/2) cycles. R=2 gives 50%; R=3 gives high 2, low 1.
  - Exactly one out_q rising edge per R reference cycles.
  - First posedge after RST deasserts: cnt=0, out_q=1.
- o_tick:
  - o_tick[k] = (cnt==0 && out_q && !bypass), decoded from registers.
  - High exactly in the first reference cycle of each divided high phase.
- Ratio update:
  - r_act reloads from i_div_ratio only on the wrap edge (cnt==r_act-1), or when term=1.
  - A mid-period change never shortens or stretches the current period.
- Bypass (i_clk_en=0 or r_act<2):
  - o_div_clk[k] = CLK, combinational mux.
  - cnt held with term=1, out_q=0, o_tick=0.
  - r_act follows i_div_ratio every cycle.
  - Leaving bypass: the next posedge starts phase 0 (out_q rises).
- i_sync:
  - Forces every channel to term=1, out_q=0 and reloads r_act.
  - Divided rising edges of all channels align on the following posedge.
- Priority: RST > i_sync > normal counting.
- Boundary cases:
  - Ratio 0 and 1 both mean bypass.
  - Ratio 2^RATIO_W-1 is the maximum; cnt never exceeds r_act-1.
- Latency: out_q is one register stage after the counter decode; no other pipelining.

Optional Feature:
- Macro: CLK_DIV_EDGE_CNT_EN.
- When defined, add port i_cnt_clr (in, 1) and port o_edge_cnt (out, NUM_CH*EDGE_CNT_W).
- Per-channel counter increments on each divided rising edge (o_tick=1). In bypass it increments every reference cycle.
- Counter wraps all-ones to 0.
- Cleared by RST or i_cnt_clr; i_cnt_clr wins over an increment in the same cycle.
- When not defined, neither port exists and no counter logic is present.

Decomposition:
- Package clk_div_pkg:
  - Default constants for NUM_CH, RATIO_W, EDGE_CNT_W.
  - Constant RATIO_BYPASS_MAX=1.
  - Function half_ceil(r) returning ceil(r/2).
- Sub-module clk_div_chan: one channel's counter, shadow ratio, out_q, tick and bypass mux.
- Top: a generate loop over NUM_CH plus sync fan-out.

Test Plan:
- CLK period 1 ns, ch0 ratio 2, en=1, 300 ns -> 150 o_div_clk rising edges, 150 o_tick pulses.
- Ratios 3, 4, 5 on ch0..ch2 for 300 ns each, counter cleared between runs -> 100, 75, 60 edges. Ratio 3 high phase exactly 2 cycles.
- ch3 en=0 for 300 ns -> o_div_clk tracks CLK, 300 edges; o_tick stays 0.
- ch0 ratio 4; write ratio 6 at cnt=1 -> current period still 4 cycles, next period 6 cycles, no runt pulse.
- ch0 ratio 4, ch1 ratio 6, pulse i_sync -> both rise on the next posedge; coincident rises every 12 cycles thereafter.
- Assert RST mid-period with ratio 5 -> outputs 0 next edge; first rise on the first posedge after release. With CLK_DIV_EDGE_CNT_EN: counter reads 0 after RST.
